ld_down_counter: RTL
====================

Name: ld_down_counter

Overview:
- Loadable down counter with terminal-count output, the counting-down counterpart of the team's free-running up counter.
- A start value is accepted through a valid/ready load handshake. The block then decrements on each enabled cycle to zero and flags terminal count.
- Terminal count either stops the counter or auto-reloads it.
- Used as a programmable timer/divider in the same clock domain as the free-running counters.

Parameters:
WIDTH, 4, counter and load-data width in bits (minimum 1).

Ports:
clk_in  input  1  single clock; all state on posedge.
rst_in  input  1  reset, asynchronous, active-high.
load_valid_in  input  1  load request; qualifies load_data_in and reload_in.
load_ready_out  output  1  block can accept a load (IDLE or DONE).
load_data_in  input  WIDTH  start/reload value.
reload_in  input  1  sampled with the load: 1 = auto-reload mode, 0 = one-shot.
en_in  input  1  count enable; decrement only when high.
count_out  output  WIDTH  current count register.
tc_out  output  1  terminal count, combinational: state==COUNT && count==0 && en_in.
busy_out  output  1  state==COUNT.
done_out  output  1  state==DONE (one-shot finished).

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - state=IDLE, count=0, reload value=0, reload mode=0.
  - load_ready_out=1, busy_out=0, done_out=0, tc_out=0.
- FSM states: IDLE, COUNT, DONE. Encoding comes from the shared package.
- IDLE or DONE:
  - load_ready_out=1.
  - If load_valid_in=1: count<=load_data_in, reload value<=load_data_in, mode<=reload_in, next state=COUNT.
  - en_in is ignored.
- COUNT:
  - load_ready_out=0; load_valid_in is ignored and no data is captured.
  - en_in=0: count holds.
  - en_in=1 and count!=0: count<=count-1.
  - en_in=1 and count==0: tc_out=1 this cycle.
    - Mode=1: count<=reload value, state stays COUNT.
    - Mode=0: count stays 0, state<=DONE.
- Latency: a load of N raises tc_out on the (N+1)th enabled cycle after the accept edge. A load of 0 gives tc_out on the first enabled cycle.
- Period: auto-reload with value N gives a tc_out pulse every N+1 enabled cycles.
- Arithmetic: unsigned WIDTH-bit. Decrement never wraps below 0; the zero case is handled by the tc rule above.
- Maximum load value 2^WIDTH-1 is legal.
- The handshake completes in one cycle when valid and ready are both high. A load accepted in DONE restarts counting; done_out drops on the next cycle.
- Reset asserted mid-count: abort immediately to reset values, discarding any pending terminal count.

Optional Feature:
- Macro LD_DOWN_COUNTER_ABORT_EN.
- Defined:
  - Adds input port abort_in (1 bit).
  - In COUNT, abort_in=1 at a clock edge forces state<=IDLE and count<=0, with no tc_out that cycle. This takes priority over en_in; tc_out is gated with !abort_in.
  - In IDLE/DONE, abort_in=1 forces IDLE and has priority over load_valid_in.
- Not defined: the port does not exist, and COUNT can only be left via terminal count (one-shot) or rst_in.

Decomposition:
- Shared package holds the state typedef/localparams (ST_IDLE=2'd0, ST_COUNT=2'd1, ST_DONE=2'd2) and the default width constant shared with the up counter.
- One sub-module is natural: ld_down_counter_core. It holds the WIDTH-bit count register with load/decrement/hold and the zero-detect. The FSM and handshake stay in the top module.

Test Plan:
1. Load 3, reload_in=0, en_in held 1 -> count_out 3,2,1,0; tc_out=1 on the 4th enabled cycle; then done_out=1, load_ready_out=1, count_out=0.
2. Load 0 one-shot, en_in=1 -> tc_out=1 on the first cycle in COUNT; DONE on the next edge.
3. Load 2, reload_in=1, en_in=1 for 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc_out pulses on cycles 3, 6, 9; busy_out stays 1.
4. Load 5, en_in toggled 1,0,0,1 -> count 5,4,4,4,3; tc_out never set while en_in=0 even at count 0.
5. Load 7, then load_valid_in=1 with data 1 during COUNT -> load_ready_out=0 and count continues 6,5,...; a load accepted in DONE restarts from the new value.
6. Load 9 and count to 6, then pulse rst_in between clock edges -> count_out=0, busy_out=0, load_ready_out=1 immediately. With LD_DOWN_COUNTER_ABORT_EN, abort_in at count 4 gives IDLE with no tc.

Source files
------------

// File: rtl/ld_down_counter_pkg.sv
// Shared definitions for the loadable down counter: FSM state encoding,
// count-register operation codes and the default width shared with the up counter.
`timescale 1ns/1ps
package ld_down_counter_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Operation applied to the count register on the next clock edge.
   typedef enum logic [2:0] {
      OP_HOLD   = 3'd0,
      OP_LOAD   = 3'd1,
      OP_DEC    = 3'd2,
      OP_RELOAD = 3'd3,
      OP_CLEAR  = 3'd4
   } core_op_t;

endpackage

// File: rtl/ld_down_counter_core.sv
// Count datapath: WIDTH-bit count register, captured reload value and zero detect.
// Performs whatever operation the controlling FSM selects each cycle.
`timescale 1ns/1ps
module ld_down_counter_core
   import ld_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  core_op_t         op,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] reload_value;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         count        <= '0;
         reload_value <= '0;
      end else begin
         unique case (op)
            OP_LOAD: begin
               count        <= load_data;
               reload_value <= load_data;
            end
            OP_DEC:    count <= count - WIDTH'(1);
            OP_RELOAD: count <= reload_value;
            OP_CLEAR:  count <= '0;
            default:   count <= count;
         endcase
      end
   end

   // Decrement is only requested when nonzero, so the register never wraps.
   assign zero = (count == '0);

endmodule

// File: rtl/ld_down_counter.sv
// Loadable down counter with terminal count, one-shot or auto-reload mode.
// Optional abort input enabled by defining LD_DOWN_COUNTER_ABORT_EN.
`timescale 1ns/1ps
module ld_down_counter
   import ld_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             load_valid_in,
   output logic             load_ready_out,
   input  logic [WIDTH-1:0] load_data_in,
   input  logic             reload_in,
   input  logic             en_in,
`ifdef LD_DOWN_COUNTER_ABORT_EN
   input  logic             abort_in,
`endif
   output logic [WIDTH-1:0] count_out,
   output logic             tc_out,
   output logic             busy_out,
   output logic             done_out
);

   state_t   state, state_next;
   logic     mode, mode_next;
   core_op_t op;
   logic     zero;
   logic     tc;
   logic     ready;
   logic     abort;

`ifdef LD_DOWN_COUNTER_ABORT_EN
   assign abort = abort_in;
`else
   assign abort = 1'b0;
`endif

   ld_down_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .op        (op),
      .load_data (load_data_in),
      .count     (count_out),
      .zero      (zero)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= ST_IDLE;
         mode  <= 1'b0;
      end else begin
         state <= state_next;
         mode  <= mode_next;
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_next = state;
      mode_next  = mode;
      op         = OP_HOLD;
      tc         = 1'b0;
      ready      = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            ready = 1'b1;
            if (abort) begin
               state_next = ST_IDLE;
               op         = OP_CLEAR;
            end else if (load_valid_in) begin
               op         = OP_LOAD;
               mode_next  = reload_in;
               state_next = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (abort) begin
               state_next = ST_IDLE;
               op         = OP_CLEAR;
            end else if (en_in) begin
               if (zero) begin
                  tc = 1'b1;
                  if (mode) begin
                     op = OP_RELOAD;
                  end else begin
                     state_next = ST_DONE;
                  end
               end else begin
                  op = OP_DEC;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            op         = OP_CLEAR;
         end
      endcase
   end

   assign load_ready_out = ready;
   assign tc_out         = tc;
   assign busy_out       = (state == ST_COUNT);
   assign done_out       = (state == ST_DONE);

endmodule
